// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared definitions for the register-file writeback sequencer: FSM states,
// requester IDs and the default register-file geometry.
package regfile_wb_sequencer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } wb_state_e;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Writeback bus: two requester handshakes, the register-file write port and
// the decode-side hazard query.
interface regfile_wb_sequencer_if
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              ws;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_reg;
  logic [ADDR_W-1:0] q_reg1;
  logic [ADDR_W-1:0] q_reg2;
  logic              hazard1;
  logic              hazard2;

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data, q_reg1, q_reg2,
    output alu_ready, ld_ready, wr_reg, wr_data, ws, pend_valid, pend_reg, hazard1, hazard2
  );

  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data, q_reg1, q_reg2,
    input  alu_ready, ld_ready, wr_reg, wr_data, ws, pend_valid, pend_reg, hazard1, hazard2
  );

endinterface

// File: rtl/regfile_wb_sequencer_arbiter.sv
// Two-requester writeback grant: fixed load priority or round-robin against
// the last accepted requester.
module wb_rr_arbiter
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic rr_last_q;
  logic rr_last_d;

  // Grant selection; a tie goes to whichever requester was not served last.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = REQ_ALU;
    case (req_i)
      2'b01:   gnt_id_o = REQ_ALU;
      2'b10:   gnt_id_o = REQ_LD;
      2'b11: begin
        if (FIXED_PRI != 0) begin
          gnt_id_o = REQ_LD;
        end else begin
          gnt_id_o = ~rr_last_q;
        end
      end
      default: gnt_id_o = REQ_ALU;
    endcase
    if (accept_i) begin
      rr_last_d = gnt_id_o;
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // Last-served register; starts at load so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= REQ_LD;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Register-file writeback sequencer: arbitrates two requesters, holds the
// write port stable for one setup cycle, then raises a one-cycle registered WS.
module regfile_wb_sequencer
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ZERO_DROP = 1,
  parameter int FIXED_PRI = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_wb_sequencer_if.slave bus
);

  wb_state_e         state_q, state_d;
  logic              ws_q, ws_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [ADDR_W-1:0] pend_reg_q, pend_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              gnt_valid_s;
  logic              gnt_id_s;
  logic              open_s;
  logic              accept_s;
  logic              drop_s;
  logic              commit_s;
  logic [ADDR_W-1:0] sel_reg_s;
  logic [DATA_W-1:0] sel_data_s;

  wb_rr_arbiter #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({bus.ld_valid, bus.alu_valid}),
    .accept_i    (accept_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Accept decision; a register-0 write is consumed without starting a write.
  always_comb begin
    open_s   = (state_q == ST_IDLE) || (state_q == ST_RELEASE);
    accept_s = open_s && gnt_valid_s;
    if (gnt_id_s == REQ_LD) begin
      sel_reg_s  = bus.ld_reg;
      sel_data_s = bus.ld_data;
    end else begin
      sel_reg_s  = bus.alu_reg;
      sel_data_s = bus.alu_data;
    end
    drop_s   = (ZERO_DROP != 0) && (sel_reg_s == ADDR_W'(REG_ZERO));
    commit_s = accept_s && !drop_s;
  end

  // Sequencer next state: ws and pend_valid are decided one cycle ahead.
  always_comb begin
    state_d      = state_q;
    ws_d         = 1'b0;
    pend_valid_d = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    pend_reg_d   = pend_reg_q;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (commit_s) begin
          state_d      = ST_SETUP;
          pend_valid_d = 1'b1;
          wr_reg_d     = sel_reg_s;
          wr_data_d    = sel_data_s;
          pend_reg_d   = sel_reg_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d      = ST_STROBE;
        ws_d         = 1'b1;
        pend_valid_d = 1'b1;
      end
      ST_STROBE: state_d = ST_RELEASE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and port registers; reset pulls ws low without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ws_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      pend_reg_q   <= '0;
    end else begin
      state_q      <= state_d;
      ws_q         <= ws_d;
      pend_valid_q <= pend_valid_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      pend_reg_q   <= pend_reg_d;
    end
  end

  assign bus.alu_ready  = accept_s && (gnt_id_s == REQ_ALU);
  assign bus.ld_ready   = accept_s && (gnt_id_s == REQ_LD);
  assign bus.wr_reg     = wr_reg_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.ws         = ws_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.pend_reg   = pend_reg_q;
  // Hazards look only at latched state, never at a same-cycle accept.
  assign bus.hazard1 = pend_valid_q && (bus.q_reg1 == pend_reg_q) && (bus.q_reg1 != ADDR_W'(REG_ZERO));
  assign bus.hazard2 = pend_valid_q && (bus.q_reg2 == pend_reg_q) && (bus.q_reg2 != ADDR_W'(REG_ZERO));

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: a round-robin and a fixed-priority instance,
// a directed vector table, hand-written corner sequences and random traffic.
module tb_regfile_wb_sequencer;
  import regfile_wb_sequencer_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          alu_valid [2];
  logic [AW-1:0] alu_reg   [2];
  logic [DW-1:0] alu_data  [2];
  logic          ld_valid  [2];
  logic [AW-1:0] ld_reg    [2];
  logic [DW-1:0] ld_data   [2];
  logic [AW-1:0] q_reg1    [2];
  logic [AW-1:0] q_reg2    [2];
  logic          alu_ready [2];
  logic          ld_ready  [2];
  logic [AW-1:0] wr_reg    [2];
  logic [DW-1:0] wr_data   [2];
  logic          ws        [2];
  logic          pend_valid[2];
  logic [AW-1:0] pend_reg  [2];
  logic          hazard1   [2];
  logic          hazard2   [2];

  // Instance 0 is round-robin, instance 1 gives the load requester fixed priority.
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    regfile_wb_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_wb_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ZERO_DROP(1), .FIXED_PRI(g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
    logic [DW-1:0] rf [32] = '{default: '0};
    int pulses = 0;
    assign bus.alu_valid = alu_valid[g];
    assign bus.alu_reg   = alu_reg[g];
    assign bus.alu_data  = alu_data[g];
    assign bus.ld_valid  = ld_valid[g];
    assign bus.ld_reg    = ld_reg[g];
    assign bus.ld_data   = ld_data[g];
    assign bus.q_reg1    = q_reg1[g];
    assign bus.q_reg2    = q_reg2[g];
    assign alu_ready[g]  = bus.alu_ready;
    assign ld_ready[g]   = bus.ld_ready;
    assign wr_reg[g]     = bus.wr_reg;
    assign wr_data[g]    = bus.wr_data;
    assign ws[g]         = bus.ws;
    assign pend_valid[g] = bus.pend_valid;
    assign pend_reg[g]   = bus.pend_reg;
    assign hazard1[g]    = bus.hazard1;
    assign hazard2[g]    = bus.hazard2;
    // Register file stand-in: captures on the rising edge of WS.
    always @(posedge bus.ws) begin
      pulses <= pulses + 1;
      if (bus.wr_reg != 5'd0) rf[bus.wr_reg] <= bus.wr_data;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      alu_valid[d] = 1'b0; alu_reg[d] = '0; alu_data[d] = '0;
      ld_valid[d]  = 1'b0; ld_reg[d]  = '0; ld_data[d]  = '0;
      q_reg1[d]    = '0;   q_reg2[d]  = '0;
    end
  endtask

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic lv; logic [4:0] lr; logic [31:0] ld;
    logic [4:0] q1; logic [4:0] q2;
    logic e_ar; logic e_lr; logic e_ws;
    logic [4:0] e_wr; logic [31:0] e_wd;
    logic e_pv; logic e_h1; logic e_h2;
  } vec_t;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'hA1A1_0001;
  localparam logic [31:0] B2 = 32'hB2B2_0002;
  localparam logic [31:0] C3 = 32'h0000_0033;

  vec_t tbl [16];

  // Reference model state, one slot per instance.
  int          m_age [2];
  logic        m_rr  [2];
  logic [4:0]  m_wr  [2];
  logic [4:0]  m_pr  [2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_rf  [2][32];
  bit          touched [2][32];
  logic        alu_took [2];
  logic        ld_took  [2];

  initial begin
    int p0;
    int na;
    int nl;
    bit got;
    idle_inputs();

    // Directed table for the round-robin instance, one row per clock cycle.
    tbl[0]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,1'b0,1'b0, 5'd0,32'h0, 1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,5'd5,DB,    1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b1,1'b0,1'b0, 5'd0,32'h0, 1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,1'b0,1'b0, 5'd5,DB,    1'b1,1'b1,1'b0};
    tbl[3]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd5,5'd0, 1'b0,1'b0,1'b1, 5'd5,DB,    1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b0,5'd0,32'h0, 1'b1,5'd0,32'h1234, 5'd5,5'd0, 1'b0,1'b1,1'b0, 5'd5,DB,    1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b1,5'd3,C3,    1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b1,1'b0,1'b0, 5'd5,DB,    1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,5'd1,A1,    1'b1,5'd2,B2,       5'd7,5'd3, 1'b0,1'b0,1'b0, 5'd3,C3,    1'b1,1'b0,1'b1};
    tbl[7]  = '{1'b1,5'd1,A1,    1'b1,5'd2,B2,       5'd7,5'd3, 1'b0,1'b0,1'b1, 5'd3,C3,    1'b1,1'b0,1'b1};
    tbl[8]  = '{1'b1,5'd1,A1,    1'b1,5'd2,B2,       5'd7,5'd3, 1'b0,1'b1,1'b0, 5'd3,C3,    1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,5'd1,A1,    1'b0,5'd0,32'h0,    5'd2,5'd0, 1'b0,1'b0,1'b0, 5'd2,B2,    1'b1,1'b1,1'b0};
    tbl[10] = '{1'b1,5'd1,A1,    1'b0,5'd0,32'h0,    5'd2,5'd0, 1'b0,1'b0,1'b1, 5'd2,B2,    1'b1,1'b1,1'b0};
    tbl[11] = '{1'b1,5'd1,A1,    1'b0,5'd0,32'h0,    5'd2,5'd0, 1'b1,1'b0,1'b0, 5'd2,B2,    1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd1,5'd1, 1'b0,1'b0,1'b0, 5'd1,A1,    1'b1,1'b1,1'b1};
    tbl[13] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd1,5'd1, 1'b0,1'b0,1'b1, 5'd1,A1,    1'b1,1'b1,1'b1};
    tbl[14] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd1,5'd1, 1'b0,1'b0,1'b0, 5'd1,A1,    1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0,    5'd0,5'd0, 1'b0,1'b0,1'b0, 5'd1,A1,    1'b0,1'b0,1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ws", 32'(ws[0]), 32'd0);
    chk("rst_pend", 32'(pend_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      alu_valid[0] = tbl[i].av; alu_reg[0] = tbl[i].ar; alu_data[0] = tbl[i].ad;
      ld_valid[0]  = tbl[i].lv; ld_reg[0]  = tbl[i].lr; ld_data[0]  = tbl[i].ld;
      q_reg1[0]    = tbl[i].q1; q_reg2[0]  = tbl[i].q2;
      @(negedge clk);
      chk("tbl_alu_ready", 32'(alu_ready[0]), 32'(tbl[i].e_ar));
      chk("tbl_ld_ready", 32'(ld_ready[0]), 32'(tbl[i].e_lr));
      chk("tbl_ws", 32'(ws[0]), 32'(tbl[i].e_ws));
      chk("tbl_wr_reg", 32'(wr_reg[0]), 32'(tbl[i].e_wr));
      chk("tbl_wr_data", wr_data[0], tbl[i].e_wd);
      chk("tbl_pend_valid", 32'(pend_valid[0]), 32'(tbl[i].e_pv));
      chk("tbl_hazard1", 32'(hazard1[0]), 32'(tbl[i].e_h1));
      chk("tbl_hazard2", 32'(hazard2[0]), 32'(tbl[i].e_h2));
    end
    chk("tbl_rf_r5", gen_dut[0].rf[5], DB);
    chk("tbl_rf_r3", gen_dut[0].rf[3], C3);
    chk("tbl_rf_r2", gen_dut[0].rf[2], B2);
    chk("tbl_rf_r1", gen_dut[0].rf[1], A1);
    chk("tbl_rf_r0", gen_dut[0].rf[0], 32'h0);
    chk("tbl_ws_pulses", 32'(gen_dut[0].pulses), 32'd4);

    // Reset during STROBE: ws drops at once, the re-presented request lands once.
    @(posedge clk); #1;
    alu_valid[0] = 1'b1; alu_reg[0] = 5'd9; alu_data[0] = 32'h99;
    @(negedge clk);
    chk("mid_accept", 32'(alu_ready[0]), 32'd1);
    @(posedge clk); #1;
    alu_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_strobe_ws", 32'(ws[0]), 32'd1);
    p0 = gen_dut[0].pulses;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ws", 32'(ws[0]), 32'd0);
    chk("mid_rst_wr_reg", 32'(wr_reg[0]), 32'd0);
    chk("mid_rst_wr_data", wr_data[0], 32'h0);
    chk("mid_rst_pend", 32'(pend_valid[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    alu_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (alu_ready[0]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    alu_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_reaccept", 32'(got), 32'd1);
    chk("mid_pulses_after", 32'(gen_dut[0].pulses - p0), 32'd1);
    chk("mid_rf_r9", gen_dut[0].rf[9], 32'h99);

    // Fixed priority: with both requesters valid the load always wins.
    alu_valid[1] = 1'b1; alu_reg[1] = 5'd1; alu_data[1] = 32'h11;
    ld_valid[1]  = 1'b1; ld_reg[1]  = 5'd2; ld_data[1]  = 32'h22;
    na = 0; nl = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (alu_ready[1]) na++;
      if (ld_ready[1]) nl++;
      @(posedge clk); #1;
    end
    ld_valid[1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (alu_ready[1]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("fix_alu_grants", 32'(na), 32'd0);
    chk("fix_ld_grants", 32'(nl), 32'd3);
    chk("fix_alu_alone", 32'(got), 32'd1);

    // Random traffic against the reference model on both instances.
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      m_age[d] = 0; m_rr[d] = 1'b1; m_wr[d] = '0; m_pr[d] = '0; m_wd[d] = '0;
      alu_took[d] = 1'b0; ld_took[d] = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_rf[d][r] = '0; touched[d][r] = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NRAND; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (!alu_valid[d] || alu_took[d]) begin
          alu_valid[d] = ($urandom_range(0, 2) != 0);
          alu_reg[d]   = 5'($urandom_range(0, 7));
          alu_data[d]  = $urandom;
        end
        if (!ld_valid[d] || ld_took[d]) begin
          ld_valid[d] = ($urandom_range(0, 2) != 0);
          ld_reg[d]   = 5'($urandom_range(0, 7));
          ld_data[d]  = $urandom;
        end
        if (cyc >= NRAND - 5) begin
          alu_valid[d] = 1'b0;
          ld_valid[d]  = 1'b0;
        end
        q_reg1[d] = 5'($urandom_range(0, 7));
        q_reg2[d] = 5'($urandom_range(0, 7));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic avail, pv, g, any, e_ar, e_lr;
        logic [4:0] dest;
        avail = (m_age[d] == 0) || (m_age[d] == 3);
        pv    = (m_age[d] == 1) || (m_age[d] == 2);
        any   = alu_valid[d] || ld_valid[d];
        if (alu_valid[d] && ld_valid[d]) g = (d == 1) ? 1'b1 : ~m_rr[d];
        else g = ld_valid[d];
        e_ar = avail && any && !g;
        e_lr = avail && any && g;
        chk("rnd_alu_ready", 32'(alu_ready[d]), 32'(e_ar));
        chk("rnd_ld_ready", 32'(ld_ready[d]), 32'(e_lr));
        chk("rnd_ws", 32'(ws[d]), 32'(m_age[d] == 2));
        chk("rnd_pend_valid", 32'(pend_valid[d]), 32'(pv));
        chk("rnd_pend_reg", 32'(pend_reg[d]), 32'(m_pr[d]));
        chk("rnd_wr_reg", 32'(wr_reg[d]), 32'(m_wr[d]));
        chk("rnd_wr_data", wr_data[d], m_wd[d]);
        chk("rnd_hazard1", 32'(hazard1[d]), 32'(pv && q_reg1[d] == m_pr[d] && q_reg1[d] != 5'd0));
        chk("rnd_hazard2", 32'(hazard2[d]), 32'(pv && q_reg2[d] == m_pr[d] && q_reg2[d] != 5'd0));
        alu_took[d] = alu_valid[d] && alu_ready[d];
        ld_took[d]  = ld_valid[d] && ld_ready[d];
        if (m_age[d] == 2 && m_wr[d] != 5'd0) begin
          m_rf[d][m_wr[d]] = m_wd[d];
          touched[d][m_wr[d]] = 1'b1;
        end
        if (e_ar || e_lr) begin
          m_rr[d] = g;
          dest = g ? ld_reg[d] : alu_reg[d];
          if (dest != 5'd0) begin
            m_wr[d] = dest;
            m_pr[d] = dest;
            m_wd[d] = g ? ld_data[d] : alu_data[d];
            m_age[d] = 1;
          end else begin
            m_age[d] = 0;
          end
        end else if (m_age[d] == 1 || m_age[d] == 2) begin
          m_age[d] = m_age[d] + 1;
        end else begin
          m_age[d] = 0;
        end
      end
    end
    for (int r = 1; r < 32; r++) begin
      if (touched[0][r]) chk("rnd_rf0", gen_dut[0].rf[r], m_rf[0][r]);
      if (touched[1][r]) chk("rnd_rf1", gen_dut[1].rf[r], m_rf[1][r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates writeback between two requesters: ALU result (req 0) and load data (req 1). Each requester uses a valid/ready handshake.
- Presents the write address and data to the register file, then generates a clean, registered rising edge on WS one full cycle later. The register file captures on that edge.
- Publishes the in-flight destination register so decode logic can detect read-after-write hazards and stall.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- ZERO_DROP, 1, when 1 a write to register 0 is accepted and discarded with no WS pulse.
- FIXED_PRI, 0, when 1 the load requester always wins; when 0 arbitration is round-robin.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when high together with alu_valid
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle when high together with ld_valid
- ld_reg  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- wr_reg  out  ADDR_W  to register file Write_Reg
- wr_data  out  DATA_W  to register file Write_Data
- ws  out  1  to register file WS; registered, glitch-free
- pend_valid  out  1  a write is in flight
- pend_reg  out  ADDR_W  destination of the in-flight write
- q_reg1  in  ADDR_W  decode read address 1
- q_reg2  in  ADDR_W  decode read address 2
- hazard1  out  1  q_reg1 matches the in-flight write
- hazard2  out  1  q_reg2 matches the in-flight write

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ws=0, wr_reg=0, wr_data=0, pend_valid=0, pend_reg=0, rr_last=1 (so ALU wins the first tie).
- States: IDLE, SETUP, STROBE, RELEASE.
- ready rules:
  - alu_ready and ld_ready are combinational.
  - Only the granted requester sees ready=1, and only in IDLE or RELEASE.
  - Both readies are 0 in SETUP and STROBE.
- Grant rules:
  - Only one valid: that requester is granted.
  - Both valid, FIXED_PRI=1: load is granted.
  - Both valid, FIXED_PRI=0: the requester not equal to rr_last is granted.
  - rr_last updates on every accept, including dropped register-0 writes.
- Accept in cycle T (valid & ready), non-zero destination or ZERO_DROP=0:
  - At the end of T: wr_reg/wr_data latch the request, pend_valid=1, pend_reg=destination, state becomes SETUP.
  - T+1 (SETUP): ws=0; address and data are stable at the register file.
  - T+2 (STROBE): ws=1; the rising edge writes the register.
  - T+3 (RELEASE): ws=0, pend_valid=0; a new accept is allowed in this cycle.
  - Sustained throughput: one write per 3 cycles.
- Accept of register 0 with ZERO_DROP=1:
  - Consumed in one cycle; no state change and no WS pulse.
  - wr_reg/wr_data keep their previous values; pend_valid is unaffected.
- Port stability: wr_reg and wr_data change only on accept. They are held through SETUP, STROBE and RELEASE.
- ws is driven directly from a flop and is high for exactly one cycle per real write.
- A requester holding valid without ready must keep reg/data stable (requester obligation); the sequencer does not re-sample until accept.
- Hazards (combinational):
  - hazardN = pend_valid & (q_regN == pend_reg) & (q_regN != 0).
  - Hazards are evaluated against latched state only. A same-cycle accept does not raise a hazard until the next cycle.
- Reset mid-operation:
  - rst_n low forces ws=0 asynchronously. A write in SETUP is lost; a write whose STROBE was cut short is not retried.
  - All state returns to the reset values; requesters re-present their requests.
- Simultaneous valid from both requesters in RELEASE: the grant follows the arbitration rule above. The loser waits at least 3 cycles.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, RELEASE=2'd3.
  - Requester IDs: REQ_ALU=0, REQ_LD=1.
  - REG_ZERO=5'd0.
  - DATA_W/ADDR_W defaults shared with the register file.
- One natural sub-module: wb_rr_arbiter, a 2-input round-robin/fixed-priority grant with rr_last tracking. The sequencer FSM, port registers and hazard compare stay in the top level.

Test Plan:
- Reset then single ALU write: alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF in cycle 1 → alu_ready=1 in cycle 1; wr_reg=5 and wr_data=0xDEADBEEF from cycle 2; ws=1 only in cycle 3; register-file read of r5 = 0xDEADBEEF; pend_valid high in cycles 2–3.
- Contention, FIXED_PRI=0: both valid continuously, alu→r1, ld→r2 → grants alternate ALU, LD, ALU at cycles 1, 4, 7; exactly one ws pulse per 3 cycles; no grant in SETUP/STROBE.
- Register-zero drop: ld_reg=0, ld_data=0x1234 → ld_ready=1, ws stays 0, r0 reads 0; a following alu write to r3 is accepted in the next cycle.
- Hazard: in-flight write to r7, q_reg1=7, q_reg2=0 → hazard1=1 in SETUP and STROBE, 0 in RELEASE; hazard2=0 throughout.
- Reset mid-write: assert rst_n=0 during STROBE → ws falls immediately; all outputs return to reset values; after release the requester re-presents and is written once.
- FIXED_PRI=1 with both valid → load wins every arbitration; the ALU is granted only when ld_valid=0.
